// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer and the Control decoder:
// opcode map, fetch FSM state encoding and instruction field positions.
package instr_fetch_seq_pkg;

  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned OPCODE_W    = 4;
  localparam int unsigned OPCODE_MSB  = INSTR_W_DEF - 1;
  localparam int unsigned OPCODE_LSB  = INSTR_W_DEF - OPCODE_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_LDI   = 4'hA,
    OP_BRZ   = 4'hB,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_e;

  // Opcode field of a default-width instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W_DEF-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic is_branch_op(input logic [OPCODE_W-1:0] op);
    return op == OP_BRZ;
  endfunction

  function automatic logic is_halt_op(input logic [OPCODE_W-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_seq_pc_next_calc.sv
// Next-PC adder: PC + 1, plus the sign-extended branch offset when the branch is taken.
// All arithmetic is modulo 2^PC_W.
module pc_next_calc
  import instr_fetch_seq_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned OFFSET_W = 8
) (
  input  logic [PC_W-1:0]     pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                take_branch,
  output logic [PC_W-1:0]     pc_next
);

  logic [PC_W-1:0] offset_ext;

  generate
    if (OFFSET_W >= PC_W) begin : g_trunc
      // Offset at least as wide as the PC: upper bits cannot affect a modulo-2^PC_W sum.
      always_comb offset_ext = offset[PC_W-1:0];
    end else begin : g_sext
      // Narrow offset: replicate its sign bit up to PC width.
      always_comb offset_ext = {{(PC_W - OFFSET_W){offset[OFFSET_W-1]}}, offset};
    end
  endgenerate

  // Sequential successor, optionally displaced by the branch offset.
  always_comb begin
    pc_next = pc + PC_W'(1) + (take_branch ? offset_ext : '0);
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, fetches one instruction at a time over a
// req/valid handshake, presents it to Control, and picks the next PC from Control's
// BRANCH/HALT feedback and the ALU ZERO flag.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter int unsigned     OFFSET_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic                IMEM_REQ,
  output logic [PC_W-1:0]     IMEM_ADDR,
  input  logic                IMEM_VALID,
  input  logic [INSTR_W-1:0]  IMEM_RDATA,
  output logic [INSTR_W-1:0]  INSTR,
  output logic [OPCODE_W-1:0] OPCODE,
  output logic                INSTR_VALID,
  input  logic                STALL,
  input  logic                BRANCH,
  input  logic                ZERO,
  input  logic                HALT,
  output logic [PC_W-1:0]     PC,
  output logic                HALTED
);

  fetch_state_e       state;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_next;
  logic               req_q;
  logic               instr_valid_q;
  logic               halted_q;
  logic [INSTR_W-1:0] instr_q;
  logic               take_branch;

  // Branch is taken only for a conditional branch whose ALU result was zero.
  always_comb begin
    take_branch = BRANCH & ZERO;
  end

  pc_next_calc #(
    .PC_W     (PC_W),
    .OFFSET_W (OFFSET_W)
  ) u_pc_next_calc (
    .pc          (pc_q),
    .offset      (instr_q[OFFSET_W-1:0]),
    .take_branch (take_branch),
    .pc_next     (pc_next)
  );

  // Fetch/issue/halt sequencer with all outputs registered.
  // IMEM_REQ is held low through reset and raised on the first edge after release;
  // afterwards it is re-armed directly by the retiring edge, so FETCH with req low
  // only ever occurs right after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_FETCH;
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (IMEM_VALID) begin
            instr_q       <= IMEM_RDATA;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!STALL) begin
            instr_valid_q <= 1'b0;
            if (HALT) begin
              halted_q <= 1'b1;
              state    <= S_HALTED;
            end else begin
              pc_q  <= pc_next;
              req_q <= 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_HALTED: begin
          req_q         <= 1'b0;
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = pc_q;
  assign PC          = pc_q;
  assign INSTR       = instr_q;
  assign OPCODE      = instr_q[INSTR_W-1 -: OPCODE_W];
  assign INSTR_VALID = instr_valid_q;
  assign HALTED      = halted_q;

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction fetch sequencer: the producer end of the OPCODE interface into the Control decoder.
- Owns the PC and fetches 16-bit instructions from instruction memory through a req/valid handshake.
- Presents OPCODE/INSTR to Control and the datapath, and consumes Control's BRANCH/HALT feedback plus the ALU ZERO flag to choose the next PC.
- Multi-cycle: one instruction is in flight at a time.

Parameters:
- PC_W, 8, PC and instruction-memory address width; PC arithmetic is modulo 2^PC_W.
- INSTR_W, 16, instruction width; OPCODE is INSTR[INSTR_W-1:INSTR_W-4].
- OFFSET_W, 8, branch offset field width, INSTR[OFFSET_W-1:0], two's complement.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IMEM_REQ  out  1  fetch request to instruction memory.
- IMEM_ADDR  out  PC_W  fetch address; equals PC.
- IMEM_VALID  in  1  instruction memory response valid.
- IMEM_RDATA  in  INSTR_W  instruction memory response data.
- INSTR  out  INSTR_W  registered current instruction.
- OPCODE  out  4  INSTR opcode field, to Control.
- INSTR_VALID  out  1  INSTR/OPCODE hold a live instruction.
- STALL  in  1  downstream not ready; holds the current instruction.
- BRANCH  in  1  from Control; the current instruction is a conditional branch.
- ZERO  in  1  ALU zero flag for the current instruction.
- HALT  in  1  from Control; the current instruction is HALT.
- PC  out  PC_W  address of the current/next fetch.
- HALTED  out  1  sequencer stopped.

Behaviour:
- Reset (RST_N low, asynchronous): state=FETCH, PC=RESET_PC, IMEM_REQ=0, INSTR=0, OPCODE=0, INSTR_VALID=0, HALTED=0.
- IMEM_REQ is a registered output. It rises on the first CLK edge after RST_N deasserts, so memory sees no request during reset.
- States: FETCH, ISSUE, HALTED.
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC, both held stable until IMEM_VALID.
  - On an edge with IMEM_REQ=1 and IMEM_VALID=1: INSTR<=IMEM_RDATA, IMEM_REQ<=0, INSTR_VALID<=1, go to ISSUE.
  - Memory latency is unbounded; there is no timeout.
- IMEM_VALID while IMEM_REQ=0 is ignored. This covers stale responses after reset and responses arriving in ISSUE or HALTED.
- ISSUE:
  - INSTR_VALID=1. OPCODE, INSTR and PC are held stable every cycle that STALL=1.
  - BRANCH, HALT and ZERO are sampled only on the edge where STALL=0; that edge retires the instruction.
  - HALT=1: go to HALTED, INSTR_VALID<=0, HALTED<=1, PC unchanged.
  - Else BRANCH=1 and ZERO=1: PC <= PC + 1 + sext(INSTR[OFFSET_W-1:0]), truncated to PC_W bits. Go to FETCH, INSTR_VALID<=0, IMEM_REQ<=1.
  - Else: PC <= PC + 1 (wraps from 2^PC_W-1 to 0). Go to FETCH, INSTR_VALID<=0, IMEM_REQ<=1.
  - HALT and BRANCH both high: HALT wins.
- HALTED:
  - IMEM_REQ=0, INSTR_VALID=0, HALTED=1.
  - INSTR/OPCODE keep the HALT instruction.
  - Stays here until RST_N is asserted.
- Throughput: with zero-wait memory (IMEM_VALID in the first REQ cycle) and no stall, one instruction retires every 2 cycles.
- Reset mid-operation: an outstanding fetch is abandoned. Its late response is dropped because IMEM_REQ=0 until the post-reset fetch begins.
- Width rules:
  - The offset is sign-extended to PC_W; when OFFSET_W>PC_W, its upper bits are dropped.
  - Negative offsets wrap modulo 2^PC_W.

Decomposition:
- Shared package:
  - opcode constants (including the HALT and branch opcodes, shared with Control);
  - state encoding FETCH/ISSUE/HALTED;
  - INSTR_W and OPCODE field position constants.
- One small combinational sub-module, pc_next_calc: inputs PC, offset, take_branch; output next PC. It is reused by any later pipelined fetch unit.
- The FSM and registers stay in instr_fetch_seq.

Test Plan:
1. Reset, then zero-wait memory returning 0x1000 at every address, STALL=0, BRANCH=HALT=0 -> IMEM_ADDR sequence 0,1,2,3; INSTR_VALID pulses on alternate cycles; OPCODE=1.
2. 3-cycle memory latency at PC=5, then STALL held high 4 cycles in ISSUE -> IMEM_ADDR=5 stable during the wait; INSTR/OPCODE stable during the stall; PC=6 only after the STALL=0 edge.
3. Instruction at PC=0x10 with offset 0xFC, BRANCH=1: with ZERO=1 -> next IMEM_ADDR=0x0D; repeat with ZERO=0 -> next IMEM_ADDR=0x11. Offset 0x7F from PC=0xF0 -> next IMEM_ADDR=0x70 (wraps).
4. HALT=1 and BRANCH=1 together at PC=7 -> HALTED=1; IMEM_REQ stays 0 for 20 cycles; PC=7. Pulse RST_N -> restart at RESET_PC.
5. PC=0xFF, no branch -> next IMEM_ADDR=0x00.
6. Assert RST_N low while in FETCH awaiting IMEM_VALID, then deliver IMEM_VALID one cycle after release -> response ignored; INSTR=0; a new request is issued at RESET_PC.
